// File: rtl/lpc_frame_sequencer_pkg.sv
// Shared types for lpc_frame_sequencer: sequencer states, warmup depth and the
// tag entry that travels alongside each sample through the encoder latency.
package lpc_frame_sequencer_pkg;

    localparam int WARMUP_SAMPLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_CLEAR = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic               valid;
        logic               warmup;
        logic               last;
        logic signed [15:0] raw;
    } tag_entry_t;

endpackage

// File: rtl/lpc_frame_sequencer_tag_delay.sv
// lpc_tag_delay: enable-gated shift register of tag entries; the tail lines up
// with the residual the encoder is presenting for the same sample.
module lpc_tag_delay
    import lpc_frame_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       iClock,
    input  logic       iReset_n,
    input  logic       iShift,
    input  tag_entry_t iTag,
    output tag_entry_t oTail
);

    tag_entry_t line_q [DEPTH];

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else if (iShift) begin
            line_q[0] <= iTag;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign oTail = line_q[DEPTH-1];

endmodule

// File: rtl/lpc_frame_sequencer.sv
// Frame sequencer feeding an LPC residual encoder and emitting warmup/residual beats.
// Optional statistics counters are compiled in with `define LPC_SEQ_STATS_EN.
module lpc_frame_sequencer
    import lpc_frame_sequencer_pkg::*;
#(
    parameter int BLOCK_SIZE  = 4096,
    parameter int ENC_LATENCY = 8
) (
    input  logic               iClock,
    input  logic               iReset_n,
    input  logic               iEnable,
    input  logic signed [15:0] iSample,
    input  logic               iSampleValid,
    output logic               oSampleReady,
    output logic signed [15:0] oEncSample,
    output logic               oEncEnable,
    output logic               oEncReset,
    input  logic signed [15:0] iEncResidual,
    output logic signed [15:0] oData,
    output logic               oValid,
    output logic               oWarmup,
    output logic               oLast,
    input  logic               iOutReady
`ifdef LPC_SEQ_STATS_EN
    ,
    output logic [15:0]        oFrameCount,
    output logic [31:0]        oStallCount
`endif
);

    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam int FC_W  = $clog2(ENC_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [IDX_W-1:0] WARM_IDX  = IDX_W'(WARMUP_SAMPLES);
    localparam logic [FC_W-1:0]  FLUSH_END = FC_W'(ENC_LATENCY - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FC_W-1:0]  flush_q, flush_d;
    tag_entry_t       tag_in;
    tag_entry_t       tail;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        flush_d      = flush_q;
        oSampleReady = 1'b0;
        oEncEnable   = 1'b0;
        oEncReset    = 1'b0;
        oEncSample   = '0;
        tag_in       = '0;
        case (state_q)
            ST_IDLE: begin
                oEncReset = 1'b1;
                if (iEnable) state_d = ST_RUN;
            end
            ST_RUN: begin
                oSampleReady = iEnable & iOutReady;
                if (oSampleReady && iSampleValid) begin
                    oEncEnable    = 1'b1;
                    oEncSample    = iSample;
                    tag_in.valid  = 1'b1;
                    tag_in.warmup = (idx_q < WARM_IDX);
                    tag_in.last   = (idx_q == LAST_IDX);
                    tag_in.raw    = iSample;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        flush_d = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                // Zero samples push the final real samples out of the encoder pipeline.
                if (iOutReady) begin
                    oEncEnable = 1'b1;
                    if (flush_q == FLUSH_END) begin
                        flush_d = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        flush_d = flush_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                oEncReset = 1'b1;
                state_d   = iEnable ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    lpc_tag_delay #(
        .DEPTH(ENC_LATENCY)
    ) u_tag_delay (
        .iClock  (iClock),
        .iReset_n(iReset_n),
        .iShift  (oEncEnable),
        .iTag    (tag_in),
        .oTail   (tail)
    );

    assign oValid  = oEncEnable & tail.valid;
    assign oWarmup = oValid & tail.warmup;
    assign oLast   = oValid & tail.last;
    assign oData   = oValid ? (tail.warmup ? tail.raw : iEncResidual) : '0;

`ifdef LPC_SEQ_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (oValid && oLast) frame_cnt_q <= frame_cnt_q + 16'd1;
            if ((state_q == ST_RUN || state_q == ST_FLUSH) && !iOutReady && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign oFrameCount = frame_cnt_q;
    assign oStallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lpc_frame_sequencer.sv
// Self-checking bench for lpc_frame_sequencer with a 4th-order fixed-difference
// encoder attached and a frame-level beat model derived from accepted samples.
module tb_lpc_frame_sequencer;

    localparam int BS = 8;
    localparam int EL = 8;

    logic               iClock = 1'b0;
    logic               iReset_n = 1'b0;
    logic               iEnable = 1'b0;
    logic signed [15:0] iSample = '0;
    logic               iSampleValid = 1'b0;
    logic               iOutReady = 1'b0;
    logic signed [15:0] iEncResidual;
    logic               oSampleReady, oEncEnable, oEncReset, oValid, oWarmup, oLast;
    logic signed [15:0] oEncSample, oData;
`ifdef LPC_SEQ_STATS_EN
    logic [15:0]        oFrameCount;
    logic [31:0]        oStallCount;
`endif

    int checks = 0;
    int errors = 0;

    always #5 iClock = ~iClock;

    lpc_frame_sequencer #(
        .BLOCK_SIZE (BS),
        .ENC_LATENCY(EL)
    ) dut (
        .iClock      (iClock),
        .iReset_n    (iReset_n),
        .iEnable     (iEnable),
        .iSample     (iSample),
        .iSampleValid(iSampleValid),
        .oSampleReady(oSampleReady),
        .oEncSample  (oEncSample),
        .oEncEnable  (oEncEnable),
        .oEncReset   (oEncReset),
        .iEncResidual(iEncResidual),
        .oData       (oData),
        .oValid      (oValid),
        .oWarmup     (oWarmup),
        .oLast       (oLast),
        .iOutReady   (iOutReady)
`ifdef LPC_SEQ_STATS_EN
        ,
        .oFrameCount (oFrameCount),
        .oStallCount (oStallCount)
`endif
    );

    // Encoder: residual = 4th difference of the sample history, EL enable pulses deep.
    logic signed [15:0] hist [4];
    logic signed [15:0] pipe [EL];
    always @(posedge iClock) begin
        if (oEncReset) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            for (int i = 0; i < EL; i++) pipe[i] <= '0;
        end else if (oEncEnable) begin
            pipe[0] <= 16'(oEncSample - 4 * hist[0] + 6 * hist[1] - 4 * hist[2] + hist[3]);
            for (int i = 1; i < EL; i++) pipe[i] <= pipe[i-1];
            hist[0] <= oEncSample;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end
    assign iEncResidual = pipe[EL-1];

    typedef struct {
        logic signed [15:0] d;
        bit                 w;
        bit                 l;
    } beat_t;

    int                 fb [BS];
    int                 mi = 0;
    beat_t              exp_q [$];
    logic signed [15:0] log_q [$];
    bit                 wlog_q [$];
    logic signed [15:0] src_q [$];
    int                 beat_cnt = 0;
    int                 last_cnt = 0;
    int                 rst_pulses = 0;
    bit                 gap_check = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic signed [15:0] expect_beat(input int i);
        if (i < 4) return 16'(fb[i]);
        return 16'(fb[i] - 4 * fb[i-1] + 6 * fb[i-2] - 4 * fb[i-3] + fb[i-4]);
    endfunction

    always @(negedge iClock) begin
        beat_t e;
        if (!iReset_n) begin
            exp_q.delete();
            mi = 0;
            gap_check = 0;
        end else begin
            if (oEncReset) rst_pulses++;
            if (!iOutReady) chk("stall_no_enable", oEncEnable, 0);
            if (oSampleReady) begin
                chk("ready_rule", iEnable && iOutReady, 1);
                chk("enable_on_accept", oEncEnable, iSampleValid);
            end
            if (oSampleReady && iSampleValid) begin
                chk("enc_sample", oEncSample, iSample);
                if (mi == 0 && gap_check) begin
                    chk("reset_pulse_between_frames", rst_pulses, 1);
                    gap_check = 0;
                end
                fb[mi] = iSample;
                exp_q.push_back('{expect_beat(mi), mi < 4, mi == BS - 1});
                mi = (mi == BS - 1) ? 0 : mi + 1;
            end
            if (oValid) begin
                chk("valid_needs_enable", oEncEnable, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", oData, e.d);
                    chk("beat_warmup", oWarmup, e.w);
                    chk("beat_last", oLast, e.l);
                end
                $display("beat %0d: data=%0d warmup=%0b last=%0b", beat_cnt, oData, oWarmup, oLast);
                log_q.push_back(oData);
                wlog_q.push_back(oWarmup);
                beat_cnt++;
                if (oLast) begin
                    last_cnt++;
                    rst_pulses = 0;
                    gap_check = 1;
                end
            end else begin
                chk("idle_flags", {oWarmup, oLast}, 0);
                chk("idle_data", oData, 0);
            end
        end
    end

    task automatic cyc(input bit rnd);
        iSampleValid = (src_q.size() > 0) && (!rnd || $urandom_range(0, 1) == 1);
        iSample      = iSampleValid ? src_q[0] : 16'($urandom);
        iOutReady    = !rnd || ($urandom_range(0, 1) == 1);
        @(negedge iClock);
        if (oSampleReady && iSampleValid) void'(src_q.pop_front());
        @(posedge iClock);
        #1;
    endtask

    task automatic run_until(input int beats, input bit rnd, input string name);
        int n = 0;
        while (beat_cnt < beats && n < 5000) begin
            cyc(rnd);
            n++;
        end
        chk({name, "_completed"}, beat_cnt >= beats, 1);
    endtask

    task automatic accept_until(input int remaining, input string name);
        int n = 0;
        while (src_q.size() > remaining && n < 2000) begin
            cyc(0);
            n++;
        end
        chk({name, "_reached"}, src_q.size(), remaining);
    endtask

    task automatic push_random_frame();
        for (int i = 0; i < BS; i++) src_q.push_back(16'($urandom));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_sready"}, oSampleReady, 0);
        chk({name, "_encen"}, oEncEnable, 0);
        chk({name, "_encrst"}, oEncReset, 1);
        chk({name, "_valid"}, oValid, 0);
        chk({name, "_warmup"}, oWarmup, 0);
        chk({name, "_last"}, oLast, 0);
        chk({name, "_data"}, oData, 0);
        chk({name, "_encsample"}, oEncSample, 0);
    endtask

    int lit [16] = '{0, 1, 16, 81, 24, 24, 24, 24, 100, 101, 102, 103, 0, 0, 0, 0};
    int base;
    int lbase;

    initial begin
        iReset_n = 1'b0;
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        check_reset_outputs("reset_state");
        @(posedge iClock);
        #1;
        iReset_n = 1'b1;
        iEnable  = 1'b1;

        // Two directed frames: n^4 then a ramp starting at 100.
        for (int n = 0; n < BS; n++) src_q.push_back(16'(n * n * n * n));
        for (int n = 0; n < BS; n++) src_q.push_back(16'(100 + n));
        run_until(16, 0, "directed");
        for (int i = 0; i < 16; i++) begin
            chk("literal_beat", log_q[i], lit[i]);
            chk("literal_warmup", wlog_q[i], (i % 8) < 4);
        end
        chk("directed_last_count", last_cnt, 2);

        // Randomised handshakes over ten frames.
        base  = beat_cnt;
        lbase = last_cnt;
        for (int f = 0; f < 10; f++) push_random_frame();
        run_until(base + 80, 1, "random");
        repeat (20) cyc(0);
        chk("random_beat_count", beat_cnt - base, 80);
        chk("random_last_count", last_cnt - lbase, 10);

        // Asynchronous reset at frame index 5.
        push_random_frame();
        accept_until(BS - 5, "reset_index5");
        #3;
        iReset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge iClock);
        @(posedge iClock);
        #3;
        iReset_n = 1'b1;
        @(posedge iClock);
        #1;
        src_q.delete();
        base = beat_cnt;
        push_random_frame();
        run_until(base + BS, 0, "after_reset");
        chk("after_reset_first_warmup", wlog_q[base], 1);

        // Enable dropped at index 3 for 20 cycles.
        base = beat_cnt;
        push_random_frame();
        accept_until(BS - 3, "pause_index3");
        iEnable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            iSampleValid = 1'b1;
            iSample      = src_q[0];
            iOutReady    = 1'b1;
            @(negedge iClock);
            chk("pause_no_accept", oSampleReady && iSampleValid, 0);
            chk("pause_no_enable", oEncEnable, 0);
            @(posedge iClock);
            #1;
        end
        iEnable = 1'b1;
        run_until(base + BS, 0, "pause_resume");
        chk("pause_remaining", src_q.size(), 0);

`ifdef LPC_SEQ_STATS_EN
        iReset_n = 1'b0;
        repeat (2) @(posedge iClock);
        #1;
        iReset_n = 1'b1;
        base = beat_cnt;
        for (int f = 0; f < 3; f++) push_random_frame();
        accept_until(3 * BS - 2, "stats_start");
        for (int i = 0; i < 7; i++) begin
            iSampleValid = 1'b1;
            iSample      = src_q[0];
            iOutReady    = 1'b0;
            @(posedge iClock);
            #1;
        end
        run_until(base + 3 * BS, 0, "stats");
        repeat (5) cyc(0);
        chk("stats_frame_count", oFrameCount, 3);
        chk("stats_stall_count", oStallCount, 7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_frame_sequencer.md
LPC_FRAME_SEQUENCER -- requirements
Module: lpc_frame_sequencer

Interface
REQ-001 Parameter BLOCK_SIZE, default 4096: samples per frame; legal range 5..65535.
REQ-002 Parameter ENC_LATENCY, default 8: encoder enable pulses from a sample's entry until its residual appears on iEncResidual.
REQ-003 Port iClock, input, 1: single clock; all state on rising edge.
REQ-004 Port iReset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port iEnable, input, 1: run permission; low pauses at the next sample boundary.
REQ-006 Ports iSample (in, 16, signed), iSampleValid (in, 1), oSampleReady (out, 1): upstream sample handshake.
REQ-007 Ports oEncSample (out, 16, signed), oEncEnable (out, 1), oEncReset (out, 1, active-high sync), iEncResidual (in, 16, signed): encoder drive and return.
REQ-008 Ports oData (out, 16, signed), oValid, oWarmup, oLast (out, 1 each), iOutReady (in, 1): downstream output stream.

Function
REQ-009 States: IDLE, RUN, FLUSH, CLEAR; the block SHALL hold exactly one at a time.
REQ-010 IDLE: oEncReset=1, oSampleReady=0; go to RUN the cycle after iEnable=1.
REQ-011 RUN: oSampleReady = iEnable & iOutReady; accept = oSampleReady & iSampleValid.
REQ-012 On accept: oEncEnable=1, oEncSample=iSample, frame index increments; oEncEnable=0 in all other RUN cycles.
REQ-013 On accepting index BLOCK_SIZE-1: go to FLUSH, index cleared.
REQ-014 FLUSH: oSampleReady=0; each cycle with iOutReady=1 gives oEncEnable=1, oEncSample=0; after ENC_LATENCY such pulses go to CLEAR.
REQ-015 CLEAR: oEncReset=1 for exactly one cycle; then RUN if iEnable=1, else IDLE.
REQ-016 Tag line, depth ENC_LATENCY, advances only when oEncEnable=1; each entry holds {valid, warmup, last, raw sample}; FLUSH inserts valid=0 entries.
REQ-017 The tail entry SHALL be aligned with the residual currently on iEncResidual.
REQ-018 Entries for frame indices 0..3 carry warmup=1; index BLOCK_SIZE-1 carries last=1.
REQ-019 oValid = oEncEnable & tail.valid; a beat transfers exactly when oValid=1, since iOutReady is already high.
REQ-020 oData = tail.warmup ? tail.raw : iEncResidual; oWarmup=tail.warmup; oLast=tail.last; oWarmup/oLast are 0 whenever oValid=0.
REQ-021 Each frame SHALL emit exactly BLOCK_SIZE beats, in order: 4 warmup, then BLOCK_SIZE-4 residuals, last beat with oLast=1.
REQ-022 iOutReady=0 SHALL stall the encoder (oEncEnable=0) in RUN and FLUSH, with no lost or duplicated beats.
REQ-023 iEnable falling mid-frame pauses acceptance only; FLUSH and CLEAR complete regardless of iEnable.
REQ-024 No arithmetic on samples; 16-bit data passes unmodified.

Reset
REQ-025 iReset_n=0 SHALL immediately force IDLE, clear index and tag line, and set outputs: oSampleReady=0, oEncEnable=0, oEncReset=1, oValid=0, oWarmup=0, oLast=0, oData=0, oEncSample=0.
REQ-026 Reset mid-frame discards the partial frame; the first frame after release restarts at index 0.

Configuration
REQ-027 Macro LPC_SEQ_STATS_EN SHALL compile in oFrameCount (16-bit, increments on each oLast beat, wraps) and oStallCount (32-bit, increments on RUN/FLUSH cycles with iOutReady=0, saturates); both reset to 0.
REQ-028 Without LPC_SEQ_STATS_EN, neither port nor counter SHALL exist; all other behaviour is identical.

Structure
REQ-029 Shared package SHALL hold the state enum, WARMUP_SAMPLES=4, and the tag-entry struct.
REQ-030 One sub-module, lpc_tag_delay (enable-gated shift register of tag entries), SHALL implement REQ-016.

Verification
REQ-031 BLOCK_SIZE=8, ENC_LATENCY=8, real encoder attached; samples n^4 for n=0..7 -> beats 0,1,16,81 (oWarmup=1), then 24,24,24,24, last with oLast=1.
REQ-032 Same frame with samples 0..7 followed by a second frame of 100..107 -> one oEncReset pulse between frames; second frame beats 100,101,102,103, then 0,0,0,0.
REQ-033 Random iOutReady (50%) and iSampleValid (50%) over 10 frames -> beat sequence identical to the unstalled run; 80 beats and 10 oLast.
REQ-034 iReset_n pulsed low at frame index 5 -> outputs reach REQ-025 values immediately; the next frame starts with 4 warmup beats.
REQ-035 iEnable dropped at index 3 for 20 cycles -> no accepts and no oEncEnable during the pause; frame completes normally.
REQ-036 With LPC_SEQ_STATS_EN, 3 frames and 7 iOutReady-low cycles -> oFrameCount=3, oStallCount=7.
